spc_stack: RTL and testbench

SPC_STACK -- requirements
Module: spc_stack

---
 rtl/spc_pkg.sv | 44 ++++
 rtl/spc_ram.sv | 32 +++
 rtl/spc_stack.sv | 99 +++++++++
 tb/tb_spc_stack.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/spc_pkg.sv
// ============================================================================
// Module      : spc_pkg
// Description : Shared constants, types and operation decode for the
//               return-address stack.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spc_pkg;

    localparam int SPC_DEPTH = 32;
    localparam int SPC_WIDTH = 19;
    localparam int SPC_PTR_W = 5;
    localparam int SPC_CNT_W = 6;

    typedef logic [SPC_PTR_W-1:0] spc_addr_t;
    typedef logic [SPC_WIDTH-1:0] spc_data_t;
    typedef logic [SPC_CNT_W-1:0] spc_cnt_t;

    localparam spc_cnt_t C_DEPTH_FULL = spc_cnt_t'(SPC_DEPTH);

    typedef enum logic [1:0] {
        SPC_OP_HOLD    = 2'd0,
        SPC_OP_PUSH    = 2'd1,
        SPC_OP_POP     = 2'd2,
        SPC_OP_REPLACE = 2'd3
    } spc_op_t;

    // A simultaneous push/pop on an empty stack has no top to replace,
    // so it degrades to a plain push.
    function automatic spc_op_t spc_decode(input logic push,
                                           input logic pop,
                                           input spc_cnt_t depth);
        spc_op_t op;
        op = SPC_OP_HOLD;
        if (push && pop && (depth != '0)) op = SPC_OP_REPLACE;
        else if (push)                    op = SPC_OP_PUSH;
        else if (pop)                     op = SPC_OP_POP;
        return op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spc_ram.sv
// ============================================================================
// Module      : spc_ram
// Description : 32 x 19 storage, one synchronous write port and one
//               asynchronous read port. Contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spc_ram
    import spc_pkg::*;
(
    input  logic      i_clk,
    input  logic      i_we,
    input  spc_addr_t i_waddr,
    input  spc_data_t i_wdata,
    input  spc_addr_t i_raddr,
    output spc_data_t o_rdata
);

    spc_data_t r_mem [SPC_DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/spc_stack.sv
// ============================================================================
// Module      : spc_stack
// Description : 32-entry return-address stack with pointer, depth and sticky
//               error flags. Optional macro SPC_STACK_OVF_TRAP_EN turns
//               push-when-full / pop-when-empty into trapped no-ops.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spc_stack
    import spc_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 PUSH,
    input  logic                 POP,
    input  logic [SPC_WIDTH-1:0] DIN,
    input  logic                 ERR_CLR,
    output logic [SPC_WIDTH-1:0] DOUT,
    output logic [SPC_PTR_W-1:0] SPTR,
    output logic                 EMPTY,
    output logic                 FULL,
    output logic                 OVF,
    output logic                 UNF
);

    spc_addr_t r_sptr;
    spc_cnt_t  r_depth;
    logic      r_ovf;
    logic      r_unf;

    spc_op_t   w_op;
    logic      w_full;
    logic      w_empty;
    logic      w_ovf_evt;
    logic      w_unf_evt;
    logic      w_push_ok;
    logic      w_pop_ok;
    logic      w_we;
    spc_addr_t w_waddr;

    assign w_op    = spc_decode(PUSH, POP, r_depth);
    assign w_full  = (r_depth == C_DEPTH_FULL);
    assign w_empty = (r_depth == '0);

`ifdef SPC_STACK_OVF_TRAP_EN
    assign w_ovf_evt = (w_op == SPC_OP_PUSH) && w_full;
    assign w_unf_evt = (w_op == SPC_OP_POP)  && w_empty;
`else
    assign w_ovf_evt = 1'b0;
    assign w_unf_evt = 1'b0;
`endif

    assign w_push_ok = (w_op == SPC_OP_PUSH) && !w_ovf_evt;
    assign w_pop_ok  = (w_op == SPC_OP_POP)  && !w_unf_evt;

    // Writes are blocked while reset is held so a push in a reset cycle
    // leaves no trace in memory either.
    assign w_we    = (w_push_ok || (w_op == SPC_OP_REPLACE)) && !RESET;
    assign w_waddr = (w_op == SPC_OP_REPLACE) ? r_sptr : r_sptr + 5'd1;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_sptr  <= 5'h1F;
            r_depth <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_sptr <= r_sptr + 5'd1;
                if (!w_full) r_depth <= r_depth + 6'd1;
            end else if (w_pop_ok) begin
                r_sptr <= r_sptr - 5'd1;
                if (!w_empty) r_depth <= r_depth - 6'd1;
            end
            // A fresh error on the clearing edge keeps the flag set.
            r_ovf <= (r_ovf && !ERR_CLR) || w_ovf_evt;
            r_unf <= (r_unf && !ERR_CLR) || w_unf_evt;
        end
    end

    spc_ram u_ram (
        .i_clk   (CLK),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (DIN),
        .i_raddr (r_sptr),
        .o_rdata (DOUT)
    );

    assign SPTR  = r_sptr;
    assign EMPTY = w_empty;
    assign FULL  = w_full;
    assign OVF   = r_ovf;
    assign UNF   = r_unf;

endmodule

`default_nettype wire

// File: tb/tb_spc_stack.sv
// ============================================================================
// Module      : tb_spc_stack
// Description : Self-checking bench for spc_stack; honours
//               SPC_STACK_OVF_TRAP_EN for the configuration-specific cases.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spc_stack;

    typedef struct {
        logic        push;
        logic        pop;
        logic        clr;
        logic [18:0] din;
        logic [4:0]  sptr;
        logic [18:0] dout;
        logic        chk_dout;
        logic        empty;
        logic        full;
        logic        ovf;
        logic        unf;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        push_i;
    logic        pop_i;
    logic        clr_i;
    logic [18:0] din_i;
    logic [18:0] dout_o;
    logic [4:0]  sptr_o;
    logic        empty_o;
    logic        full_o;
    logic        ovf_o;
    logic        unf_o;

    int   checks = 0;
    int   errors = 0;
    vec_t sb[$];
    vec_t tbl[11];
    logic [18:0] vals[32];

    spc_stack dut (
        .CLK     (clk),
        .RESET   (rst),
        .PUSH    (push_i),
        .POP     (pop_i),
        .DIN     (din_i),
        .ERR_CLR (clr_i),
        .DOUT    (dout_o),
        .SPTR    (sptr_o),
        .EMPTY   (empty_o),
        .FULL    (full_o),
        .OVF     (ovf_o),
        .UNF     (unf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic push, input logic pop, input logic clr,
                                input logic [18:0] din, input logic [4:0] sptr,
                                input logic [18:0] dout, input logic chk_dout,
                                input logic empty, input logic full,
                                input logic ovf, input logic unf);
        vec_t v;
        v.push = push; v.pop = pop; v.clr = clr; v.din = din;
        v.sptr = sptr; v.dout = dout; v.chk_dout = chk_dout;
        v.empty = empty; v.full = full; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    task automatic check(input string nm);
        vec_t e;
        logic bad;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, nothing expected", nm);
            return;
        end
        e = sb.pop_front();
        checks++;
        bad = (sptr_o !== e.sptr) || (empty_o !== e.empty) || (full_o !== e.full) ||
              (ovf_o !== e.ovf) || (unf_o !== e.unf) ||
              (e.chk_dout && (dout_o !== e.dout));
        if (bad) begin
            errors++;
            $display("FAIL %s: got sptr=%h dout=%h empty=%b full=%b ovf=%b unf=%b; expected sptr=%h dout=%h(chk=%b) empty=%b full=%b ovf=%b unf=%b",
                     nm, sptr_o, dout_o, empty_o, full_o, ovf_o, unf_o,
                     e.sptr, e.dout, e.chk_dout, e.empty, e.full, e.ovf, e.unf);
        end
    endtask

    task automatic step(input string nm, input vec_t v);
        @(negedge clk);
        push_i = v.push; pop_i = v.pop; clr_i = v.clr; din_i = v.din;
        sb.push_back(v);
        @(posedge clk);
        #1;
        check(nm);
    endtask

    task automatic do_reset();
        @(negedge clk);
        push_i = 1'b0; pop_i = 1'b0; clr_i = 1'b0; din_i = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        sb.push_back(mk(0, 0, 0, '0, 5'h1F, '0, 0, 1, 0, 0, 0));
        check("reset_state");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; push_i = 1'b0; pop_i = 1'b0; clr_i = 1'b0; din_i = '0;

        //           push pop clr din        sptr   dout      chk empty full ovf unf
        tbl[0]  = mk(1, 0, 0, 19'h00100, 5'h00, 19'h00100, 1, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 19'h00200, 5'h01, 19'h00200, 1, 0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 19'h00AAA, 5'h02, 19'h00AAA, 1, 0, 0, 0, 0);
        tbl[3]  = mk(1, 1, 0, 19'h00555, 5'h02, 19'h00555, 1, 0, 0, 0, 0);
        tbl[4]  = mk(0, 1, 0, 19'h00000, 5'h01, 19'h00200, 1, 0, 0, 0, 0);
        tbl[5]  = mk(1, 1, 0, 19'h00123, 5'h01, 19'h00123, 1, 0, 0, 0, 0);
        tbl[6]  = mk(0, 1, 0, 19'h00000, 5'h00, 19'h00100, 1, 0, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 19'h7FFFF, 5'h00, 19'h00100, 1, 0, 0, 0, 0);
        tbl[8]  = mk(0, 1, 0, 19'h00000, 5'h1F, 19'h00000, 0, 1, 0, 0, 0);
        tbl[9]  = mk(1, 1, 0, 19'h00777, 5'h00, 19'h00777, 1, 0, 0, 0, 0);
        tbl[10] = mk(0, 1, 0, 19'h00000, 5'h1F, 19'h00000, 0, 1, 0, 0, 0);

        for (int i = 0; i < 32; i++) vals[i] = 19'h10000 + 19'(i * 37) + 19'(i << 12);

        do_reset();
        for (int i = 0; i < 11; i++) step($sformatf("tbl_%0d", i), tbl[i]);

        // Fill to 32 then drain, checking LIFO order and the full/empty edges.
        do_reset();
        for (int i = 0; i < 32; i++)
            step($sformatf("fill_%0d", i),
                 mk(1, 0, 0, vals[i], 5'(i), vals[i], 1, 0, (i == 31), 0, 0));

`ifdef SPC_STACK_OVF_TRAP_EN
        step("trap_push_full", mk(1, 0, 0, 19'h7FFFF, 5'h1F, vals[31], 1, 0, 1, 1, 0));
        step("trap_clr_vs_new_ovf", mk(1, 0, 1, 19'h7FFFF, 5'h1F, vals[31], 1, 0, 1, 1, 0));
        step("trap_clr_ovf", mk(0, 0, 1, 19'h00000, 5'h1F, vals[31], 1, 0, 1, 0, 0));
`else
        step("wrap_push_full", mk(1, 0, 0, 19'h7FFFF, 5'h00, 19'h7FFFF, 1, 0, 1, 0, 0));
        step("wrap_pop_after", mk(0, 1, 0, 19'h00000, 5'h1F, vals[31], 1, 0, 0, 0, 0));
        do_reset();
        for (int i = 0; i < 32; i++)
            step($sformatf("refill_%0d", i),
                 mk(1, 0, 0, vals[i], 5'(i), vals[i], 1, 0, (i == 31), 0, 0));
`endif

        for (int k = 0; k < 32; k++)
            step($sformatf("drain_%0d", k),
                 mk(0, 1, 0, 19'h00000, 5'(30 - k), vals[(30 - k) & 31], (k < 31),
                    (k == 31), 0, 0, 0));

`ifdef SPC_STACK_OVF_TRAP_EN
        step("trap_pop_empty", mk(0, 1, 0, 19'h00000, 5'h1F, '0, 0, 1, 0, 0, 1));
        step("trap_clr_unf", mk(0, 0, 1, 19'h00000, 5'h1F, '0, 0, 1, 0, 0, 0));
`else
        step("wrap_pop_empty", mk(0, 1, 0, 19'h00000, 5'h1E, '0, 0, 1, 0, 0, 0));
        step("wrap_clr_noop", mk(0, 0, 1, 19'h00000, 5'h1E, '0, 0, 1, 0, 0, 0));
`endif

        // Asynchronous reset between edges at depth 5, then a push held over
        // a reset edge must be discarded.
        do_reset();
        for (int i = 0; i < 5; i++)
            step($sformatf("pre_async_%0d", i),
                 mk(1, 0, 0, vals[i], 5'(i), vals[i], 1, 0, 0, 0, 0));
        @(negedge clk);
        push_i = 1'b1; pop_i = 1'b0; clr_i = 1'b0; din_i = 19'h0BEEF;
        #1 rst = 1'b1;
        #1;
        sb.push_back(mk(0, 0, 0, '0, 5'h1F, '0, 0, 1, 0, 0, 0));
        check("async_reset_immediate");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; push_i = 1'b0;
        #1;
        sb.push_back(mk(0, 0, 0, '0, 5'h1F, '0, 0, 1, 0, 0, 0));
        check("push_during_reset_discarded");
        step("first_after_release", mk(1, 0, 0, 19'h00100, 5'h00, 19'h00100, 1, 0, 0, 0, 0));

        @(negedge clk);
        push_i = 1'b0; pop_i = 1'b0; clr_i = 1'b0;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d entries remain, 0 expected", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
